// File: rtl/lab1_gate_checker_if.sv
// Signal bundle between the gate checker and the gate-under-test / test controller.
// The master modport is the checker side; the slave modport is the environment side.
interface lab1_gate_checker_if;
  logic       start;
  logic       drvA;
  logic       drvB;
  logic       dutAND;
  logic       dutOR;
  logic       dutNOT;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] errCount;
  logic [3:0] errVec;

  modport master (
    input  start, dutAND, dutOR, dutNOT,
    output drvA, drvB, busy, done, pass, errCount, errVec
  );

  modport slave (
    output start, dutAND, dutOR, dutNOT,
    input  drvA, drvB, busy, done, pass, errCount, errVec
  );
endinterface

// File: rtl/lab1_gate_checker.sv
// Exhaustive two-input checker for an AND/OR/NOT gate cell: walks all four input
// vectors, lets each settle, and accumulates per-gate mismatches.
module lab1_gate_checker #(
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  reset,
  lab1_gate_checker_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} stateT;

  localparam logic [3:0] LastWait = 4'(SETTLE - 1);

  stateT      stateQ, stateD;
  logic [1:0] idxQ;
  logic [3:0] waitQ;
  logic [3:0] errCountQ;
  logic [3:0] errVecQ;
  logic [1:0] mism;

  // Expected responses are derived from the vector index, which is what drvA/drvB show.
  always_comb begin
    mism = {1'b0, bus.dutAND != (idxQ[1] & idxQ[0])}
         + {1'b0, bus.dutOR  != (idxQ[1] | idxQ[0])}
         + {1'b0, bus.dutNOT != ~idxQ[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle, StDone: if (bus.start) stateD = StSettle;
      StSettle:       if (waitQ == LastWait) stateD = StCheck;
      StCheck:        stateD = (idxQ == 2'd3) ? StDone : StSettle;
      default:        stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idxQ      <= 2'd0;
      waitQ     <= 4'd0;
      errCountQ <= 4'd0;
      errVecQ   <= 4'd0;
    end else begin
      unique case (stateQ)
        StIdle, StDone: begin
          if (bus.start) begin
            idxQ      <= 2'd0;
            waitQ     <= 4'd0;
            errCountQ <= 4'd0;
            errVecQ   <= 4'd0;
          end
        end
        StSettle: waitQ <= waitQ + 4'd1;
        StCheck: begin
          errCountQ <= errCountQ + {2'b00, mism};
          if (mism != 2'd0) errVecQ[idxQ] <= 1'b1;
          if (idxQ != 2'd3) begin
            idxQ  <= idxQ + 2'd1;
            waitQ <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.drvA     = idxQ[1];
    bus.drvB     = idxQ[0];
    bus.busy     = (stateQ == StSettle) || (stateQ == StCheck);
    bus.done     = (stateQ == StDone);
    bus.pass     = (stateQ == StDone) && (errCountQ == 4'd0);
    bus.errCount = errCountQ;
    bus.errVec   = errVecQ;
  end

endmodule

// File: tb/tb_lab1_gate_checker.sv
// Directed bench for lab1_gate_checker at SETTLE=1 and SETTLE=3 against a NOR-built
// gate model with selectable faults; expected results go through a scoreboard queue.
module tb_lab1_gate_checker;

  typedef struct {
    int         edges;
    logic [3:0] cnt;
    logic [3:0] vec;
    logic       pss;
  } expT;

  logic clk;
  logic rst1;
  logic rst3;
  int   mode1;
  int   mode3;
  int   nTests;
  int   nFail;
  expT  sbq[$];

  lab1_gate_checker_if b1 ();
  lab1_gate_checker_if b3 ();

  lab1_gate_checker #(.SETTLE(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1.master));
  lab1_gate_checker #(.SETTLE(3)) dut3 (.clk(clk), .reset(rst3), .bus(b3.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NOR-only gate cell; mode 1 = AND stuck at 0, 2 = OR inverted, 3 = all inverted
  function automatic logic [2:0] gateModel(input int mode, input logic a, input logic b);
    logic na, nb, nab, andV, orV, notV;
    na   = ~(a | a);
    nb   = ~(b | b);
    nab  = ~(a | b);
    andV = ~(na | nb);
    orV  = ~(nab | nab);
    notV = na;
    if (mode == 1) andV = 1'b0;
    if (mode == 2) orV = ~orV;
    if (mode == 3) begin
      andV = ~andV;
      orV  = ~orV;
      notV = ~notV;
    end
    return {andV, orV, notV};
  endfunction

  always_comb begin
    {b1.dutAND, b1.dutOR, b1.dutNOT} = gateModel(mode1, b1.drvA, b1.drvB);
    {b3.dutAND, b3.dutOR, b3.dutNOT} = gateModel(mode3, b3.drvA, b3.drvB);
  end

  function automatic expT expFor(input int mode, input int s);
    expT e;
    e.edges = 4 * (s + 1);
    case (mode)
      1:       begin e.vec = 4'b1000; e.cnt = 4'd1;  end
      2:       begin e.vec = 4'b1111; e.cnt = 4'd4;  end
      3:       begin e.vec = 4'b1111; e.cnt = 4'd12; end
      default: begin e.vec = 4'b0000; e.cnt = 4'd0;  end
    endcase
    e.pss = (e.cnt == 4'd0);
    return e;
  endfunction

  // {drvA, drvB, busy, done, pass, errCount, errVec}
  function automatic logic [12:0] outs(input int inst);
    if (inst == 0)
      return {b1.drvA, b1.drvB, b1.busy, b1.done, b1.pass, b1.errCount, b1.errVec};
    return {b3.drvA, b3.drvB, b3.busy, b3.done, b3.pass, b3.errCount, b3.errVec};
  endfunction

  task automatic setStart(input int inst, input logic v);
    if (inst == 0) b1.start = v;
    else b3.start = v;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nTests++;
    assert (got === want) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One full run; extraAt > 0 pulses start again so that edge extraAt samples it.
  task automatic run(input int inst, input int mode, input int extraAt);
    int          s;
    int          k;
    int          doneEdge;
    int          drvErr;
    expT         e;
    logic [12:0] o;
    s = (inst == 0) ? 1 : 3;
    if (inst == 0) mode1 = mode;
    else mode3 = mode;
    sbq.push_back(expFor(mode, s));
    @(negedge clk);
    setStart(inst, 1'b1);
    @(negedge clk);
    setStart(inst, 1'b0);
    k        = 0;
    doneEdge = -1;
    drvErr   = 0;
    o        = outs(inst);
    while (doneEdge < 0 && k <= 4 * (s + 1) + 8) begin
      o = outs(inst);
      if (o[9]) begin
        doneEdge = k;
      end else begin
        if (o[12:11] !== 2'(k / (s + 1)) || o[10] !== 1'b1) drvErr++;
        if (k + 1 == extraAt) setStart(inst, 1'b1);
        @(negedge clk);
        setStart(inst, 1'b0);
        k++;
      end
    end
    e = sbq.pop_front();
    check("done_edge", doneEdge, e.edges);
    check("err_count", {28'd0, o[7:4]}, {28'd0, e.cnt});
    check("err_vec", {28'd0, o[3:0]}, {28'd0, e.vec});
    check("pass", {31'd0, o[8]}, {31'd0, e.pss});
    check("drv_seq_errors", drvErr, 0);
    repeat (2) @(negedge clk);
    o = outs(inst);
    check("done_hold", {19'd0, o}, {19'd0, 4'b1101, e.pss, e.cnt, e.vec});
  endtask

  initial begin
    logic [12:0] o;
    nTests   = 0;
    nFail    = 0;
    mode1    = 0;
    mode3    = 0;
    b1.start = 1'b0;
    b3.start = 1'b0;
    rst1     = 1'b1;
    rst3     = 1'b1;
    @(negedge clk);
    check("reset_state_s1", {19'd0, outs(0)}, 32'd0);
    check("reset_state_s3", {19'd0, outs(1)}, 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {19'd0, outs(0)}, 32'd0);

    run(0, 0, -1);
    run(0, 1, -1);
    run(0, 2, -1);
    run(0, 3, -1);
    run(0, 0, 3);

    // Reset in the middle of a run with OR inverted, so partial errors exist
    mode1 = 2;
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (4) @(negedge clk);
    o = outs(0);
    check("partial_count", {28'd0, o[7:4]}, 32'd2);
    @(posedge clk);
    #2 rst1 = 1'b1;
    #1;
    check("reset_async", {19'd0, outs(0)}, 32'd0);
    @(negedge clk);
    check("reset_hold", {19'd0, outs(0)}, 32'd0);
    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_wait", {19'd0, outs(0)}, 32'd0);
    run(0, 0, -1);

    run(1, 0, -1);
    run(1, 3, -1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
